// File: rtl/switch_pkg.sv
// switch_pkg: shared arbiter state enum, default timing constants and channel-index width helper for switch_bank_debouncer
package switch_pkg;
  typedef enum logic {ARB_IDLE, ARB_PRESENT} arb_state_e;
  localparam int DEF_NUM_CH        = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_DEBOUNCE_BITS = 10;
  localparam int DEF_DEBOUNCE_MAX  = 1000;
  localparam int DEF_HOLD_BITS     = 26;
  localparam int DEF_HOLD_MAX      = 25_000_000;
  localparam int DEF_REPEAT_MAX    = 5_000_000;
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/switch_bank_debouncer_if.sv
// switch_bank_debouncer_if: switch pins, per-channel level/pulse outputs and press-event valid/ready stream; master = debouncer, slave = consumer
interface switch_bank_debouncer_if
  import switch_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
);
  localparam int CW = ch_width(NUM_CH);
  logic [NUM_CH-1:0] sw_in;
  logic [NUM_CH-1:0] level_out;
  logic [NUM_CH-1:0] rise_pulse;
  logic [NUM_CH-1:0] fall_pulse;
  logic [NUM_CH-1:0] repeat_pulse;
  logic              event_valid;
  logic [CW-1:0]     event_ch;
  logic              event_repeat;
  logic              event_ready;
  modport master (
    input  sw_in, event_ready,
    output level_out, rise_pulse, fall_pulse, repeat_pulse, event_valid, event_ch, event_repeat
  );
  modport slave (
    output sw_in, event_ready,
    input  level_out, rise_pulse, fall_pulse, repeat_pulse, event_valid, event_ch, event_repeat
  );
endinterface

// File: rtl/switch_debounce_cell.sv
// switch_debounce_cell: one channel sync/debounce/edge pulses, hold auto-repeat when SWITCH_AUTOREPEAT_EN; ports clk, rst, i_sw, o_level, o_rise, o_fall, o_repeat, o_rise_nxt, o_repeat_nxt
module switch_debounce_cell
  import switch_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_BITS = DEF_DEBOUNCE_BITS,
  parameter int DEBOUNCE_MAX  = DEF_DEBOUNCE_MAX,
  parameter int HOLD_BITS     = DEF_HOLD_BITS,
  parameter int HOLD_MAX      = DEF_HOLD_MAX,
  parameter int REPEAT_MAX    = DEF_REPEAT_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_repeat,
  output logic o_rise_nxt,
  output logic o_repeat_nxt
);
  localparam logic [DEBOUNCE_BITS-1:0] DMAX = DEBOUNCE_BITS'(DEBOUNCE_MAX);
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_MAX < 0 || longint'(DEBOUNCE_MAX) >= (longint'(1) << DEBOUNCE_BITS)) begin : g_bad_db
    $error("DEBOUNCE_MAX does not fit in DEBOUNCE_BITS");
  end
  if (HOLD_MAX < 1 || REPEAT_MAX < 1 || longint'(HOLD_MAX) >= (longint'(1) << HOLD_BITS) ||
      longint'(REPEAT_MAX) >= (longint'(1) << HOLD_BITS)) begin : g_bad_hold
    $error("HOLD_MAX/REPEAT_MAX must be 1..2**HOLD_BITS-1");
  end
  logic [SYNC_STAGES-1:0]   r_sync;
  logic [DEBOUNCE_BITS-1:0] r_cnt;
  logic                     r_stable, r_rise, r_fall, w_diff, w_flip;
  always_comb begin
    w_diff = r_sync[SYNC_STAGES-1] ^ r_stable;
    w_flip = w_diff && (r_cnt == DMAX);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_sw};
      r_cnt    <= (w_diff && !w_flip) ? r_cnt + 1'b1 : '0;
      r_stable <= r_stable ^ w_flip;
      r_rise   <= w_flip & ~r_stable;
      r_fall   <= w_flip & r_stable;
    end
  end
  assign o_level    = r_stable;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_rise_nxt = w_flip & ~r_stable;
`ifdef SWITCH_AUTOREPEAT_EN
  localparam logic [HOLD_BITS-1:0] HMAX = HOLD_BITS'(HOLD_MAX);
  localparam logic [HOLD_BITS-1:0] RMAX = HOLD_BITS'(REPEAT_MAX);
  logic [HOLD_BITS-1:0] r_hold, w_hold_inc;
  logic                 r_phase, r_rep, w_hit;
  always_comb begin
    w_hold_inc = r_hold + 1'b1;
    w_hit      = r_stable && !w_flip && (w_hold_inc == (r_phase ? RMAX : HMAX));
  end
  always_ff @(posedge clk) begin
    if (rst || !r_stable || w_flip) begin
      r_hold  <= '0;
      r_phase <= 1'b0;
      r_rep   <= 1'b0;
    end else begin
      r_hold  <= w_hit ? '0 : w_hold_inc;
      r_phase <= r_phase | w_hit;
      r_rep   <= w_hit;
    end
  end
  assign o_repeat     = r_rep;
  assign o_repeat_nxt = w_hit;
`else
  assign o_repeat     = 1'b0;
  assign o_repeat_nxt = 1'b0;
`endif
endmodule

// File: rtl/switch_bank_debouncer.sv
// switch_bank_debouncer: NUM_CH debounced switches with edge/auto-repeat (SWITCH_AUTOREPEAT_EN) pulses and a round-robin press-event stream; ports clk, rst, bus (switch_bank_debouncer_if.master)
module switch_bank_debouncer
  import switch_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_BITS = DEF_DEBOUNCE_BITS,
  parameter int DEBOUNCE_MAX  = DEF_DEBOUNCE_MAX,
  parameter int HOLD_BITS     = DEF_HOLD_BITS,
  parameter int HOLD_MAX      = DEF_HOLD_MAX,
  parameter int REPEAT_MAX    = DEF_REPEAT_MAX
) (
  input logic clk,
  input logic rst,
  switch_bank_debouncer_if.master bus
);
  localparam int CW = ch_width(NUM_CH);
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
    $error("NUM_CH must be 1..16");
  end
  logic [NUM_CH-1:0] w_level, w_rise, w_fall, w_rep, w_rise_nxt, w_rep_nxt;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    switch_debounce_cell #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_BITS(DEBOUNCE_BITS), .DEBOUNCE_MAX(DEBOUNCE_MAX),
      .HOLD_BITS(HOLD_BITS), .HOLD_MAX(HOLD_MAX), .REPEAT_MAX(REPEAT_MAX)
    ) u_cell (
      .clk(clk), .rst(rst), .i_sw(bus.sw_in[i]),
      .o_level(w_level[i]), .o_rise(w_rise[i]), .o_fall(w_fall[i]), .o_repeat(w_rep[i]),
      .o_rise_nxt(w_rise_nxt[i]), .o_repeat_nxt(w_rep_nxt[i])
    );
  end
  function automatic logic [CW-1:0] rr_pick(input logic [NUM_CH-1:0] req, input logic [CW-1:0] last);
    logic [CW-1:0] pick;
    pick = last;
    for (int k = NUM_CH; k >= 1; k--)
      if (req[(int'(last) + k) % NUM_CH]) pick = CW'((int'(last) + k) % NUM_CH);
    return pick;
  endfunction
  arb_state_e        r_state, w_state_nxt;
  logic [NUM_CH-1:0] r_pend, r_pend_rep, w_set, w_clr;
  logic [CW-1:0]     r_last, r_ch, w_pick;
  logic              r_rep, w_grant;
  // pend is loaded from the pulse D-inputs so a grant can follow the pulse by one cycle
  always_comb begin
    w_set       = w_rise_nxt | w_rep_nxt;
    w_pick      = rr_pick(r_pend, r_last);
    w_grant     = (|r_pend) && (r_state == ARB_IDLE || bus.event_ready);
    w_clr       = w_grant ? (NUM_CH'(1) << w_pick) : '0;
    w_state_nxt = w_grant ? ARB_PRESENT : (bus.event_ready ? ARB_IDLE : r_state);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_pend     <= '0;
      r_pend_rep <= '0;
      r_last     <= CW'(NUM_CH - 1);
      r_ch       <= '0;
      r_rep      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend     <= (r_pend & ~w_clr) | w_set;
      r_pend_rep <= (r_pend_rep & ~w_set) | w_rep_nxt;
      if (w_grant) begin
        r_ch   <= w_pick;
        r_rep  <= r_pend_rep[w_pick];
        r_last <= w_pick;
      end
    end
  end
  assign bus.level_out    = w_level;
  assign bus.rise_pulse   = w_rise;
  assign bus.fall_pulse   = w_fall;
  assign bus.repeat_pulse = w_rep;
  assign bus.event_valid  = (r_state == ARB_PRESENT);
  assign bus.event_ch     = r_ch;
  assign bus.event_repeat = r_rep;
endmodule

// File: tb/tb_switch_bank_debouncer.sv
// tb_switch_bank_debouncer: directed and random stimulus checked every cycle against a behavioural model of the debouncer bank
module tb_switch_bank_debouncer;
  localparam int N = 4, SS = 2, DB = 4, HM = 20, RM = 8;
  typedef struct {int ch; bit rep; int cyc;} acc_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] sw = '0;
  logic ready = 1'b0;
  int n_chk = 0, n_pass = 0, cyc = 0;
  int rise_cnt[N], fall_cnt[N];
  acc_t acc_q[$];
  bit m_q[N][$];
  int m_mism[N], m_held[N];
  bit [N-1:0] m_stable, m_rise, m_fall, m_rep, m_pend, m_pend_rep;
  bit m_valid, m_erep;
  int m_ch, m_last;
  switch_bank_debouncer_if #(.NUM_CH(N)) bus ();
  assign bus.sw_in = sw;
  assign bus.event_ready = ready;
  switch_bank_debouncer #(
    .NUM_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_BITS(10), .DEBOUNCE_MAX(DB),
    .HOLD_BITS(26), .HOLD_MAX(HM), .REPEAT_MAX(RM)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at cycle %0d", nm, got, exp, cyc);
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  function automatic logic [31:0] all_outs();
    return 32'({bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.repeat_pulse,
                bus.event_valid, bus.event_ch, bus.event_repeat});
  endfunction
  // Reference: delay line for the synchroniser, mismatch run length for debounce,
  // cycles-since-rise arithmetic for repeats, pending bits plus rotating priority for the stream.
  task automatic model_step();
    bit s;
    int pick;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_q[i].delete();
        for (int k = 0; k < SS; k++) m_q[i].push_back(1'b0);
        m_mism[i] = 0;
        m_held[i] = 0;
      end
      m_stable = '0; m_rise = '0; m_fall = '0; m_rep = '0; m_pend = '0; m_pend_rep = '0;
      m_valid = 0; m_erep = 0; m_ch = 0; m_last = N - 1;
      return;
    end
    pick = -1;
    for (int k = 1; k <= N; k++)
      if (pick < 0 && m_pend[(m_last + k) % N]) pick = (m_last + k) % N;
    if (pick >= 0 && (!m_valid || ready)) begin
      m_valid = 1; m_ch = pick; m_erep = m_pend_rep[pick]; m_last = pick; m_pend[pick] = 0;
    end else if (m_valid && ready) m_valid = 0;
    for (int i = 0; i < N; i++) begin
      s = m_q[i].pop_front();
      m_q[i].push_back(sw[i]);
      m_rise[i] = 0; m_fall[i] = 0; m_rep[i] = 0;
      if (s != m_stable[i]) begin
        m_mism[i]++;
        if (m_mism[i] == DB + 1) begin
          m_stable[i] = s; m_mism[i] = 0; m_rise[i] = s; m_fall[i] = !s;
        end
      end else m_mism[i] = 0;
      if (m_rise[i]) m_held[i] = 0;
      else if (m_stable[i]) m_held[i]++;
      else m_held[i] = 0;
`ifdef SWITCH_AUTOREPEAT_EN
      if (m_stable[i] && !m_rise[i] && m_held[i] >= HM && (m_held[i] - HM) % RM == 0) m_rep[i] = 1;
`endif
      if (m_rise[i] || m_rep[i]) begin
        m_pend[i] = 1;
        m_pend_rep[i] = m_rep[i];
      end
    end
  endtask
  initial begin
    logic pv, prep;
    int pch;
    pv = 0; prep = 0; pch = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (pv && ready && !rst) acc_q.push_back('{pch, prep, cyc});
      model_step();
      #1;
      chk("mdl_level", 32'(bus.level_out), 32'(m_stable));
      chk("mdl_rise", 32'(bus.rise_pulse), 32'(m_rise));
      chk("mdl_fall", 32'(bus.fall_pulse), 32'(m_fall));
      chk("mdl_repeat", 32'(bus.repeat_pulse), 32'(m_rep));
      chk("mdl_valid", 32'(bus.event_valid), 32'(m_valid));
      if (m_valid) chk("mdl_event", 32'({bus.event_ch, bus.event_repeat}), 32'({2'(m_ch), m_erep}));
      for (int i = 0; i < N; i++) begin
        rise_cnt[i] += int'(bus.rise_pulse[i]);
        fall_cnt[i] += int'(bus.fall_pulse[i]);
      end
      pv = bus.event_valid; pch = int'(bus.event_ch); prep = bus.event_repeat;
    end
  end
  initial begin
    int r0, n0, n1, f0, rt, nrep, t;
    bit ok;
    int offs[$];
    int dwell[N];
    tick(); tick();
    chk("reset_outs", all_outs(), 0);
    rst = 0;
    // clean step on ch0: level and rise exactly 7 cycles after the input edge
    sw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 7) chk("lat_pre_level", 32'(bus.level_out[0]), 0);
      if (k == 7) begin
        chk("lat_level", 32'(bus.level_out[0]), 1);
        chk("lat_rise", 32'(bus.rise_pulse[0]), 1);
      end
      if (k == 8) begin
        chk("rise_one_cycle", 32'(bus.rise_pulse[0]), 0);
        chk("ev_after_rise", 32'({bus.event_valid, bus.event_ch}), 32'({1'b1, 2'd0}));
      end
    end
    ready = 1; tick(); tick();
    chk("ev_drained", 32'(bus.event_valid), 0);
    ready = 0;
    // glitches on ch1
    r0 = rise_cnt[1];
    sw[1] = 1; repeat (3) tick(); sw[1] = 0; repeat (12) tick();
    chk("glitch3_no_rise", 32'(rise_cnt[1] - r0), 0);
    chk("glitch3_no_event", 32'(bus.event_valid), 0);
    sw[1] = 1; repeat (5) tick(); sw[1] = 0; repeat (20) tick();
    chk("pulse5_rise", 32'(rise_cnt[1] - r0), 1);
    chk("pulse5_event", 32'({bus.event_valid, bus.event_ch}), 32'({1'b1, 2'd1}));
    // simultaneous rises on ch1..3 drain back-to-back
    sw = '0; rst = 1; tick(); rst = 0; tick();
    ready = 1; n0 = acc_q.size(); sw = 4'b1110;
    for (t = 0; t < 30 && acc_q.size() < n0 + 3; t++) tick();
    chk("b2b_count", 32'(acc_q.size()), 32'(n0 + 3));
    if (acc_q.size() >= n0 + 3) begin
      chk("b2b_first", 32'(acc_q[n0].ch), 1);
      chk("b2b_second", 32'(acc_q[n0+1].ch), 2);
      chk("b2b_third", 32'(acc_q[n0+2].ch), 3);
      chk("b2b_span", 32'(acc_q[n0+2].cyc - acc_q[n0].cyc), 2);
    end
    // release: falls only, nothing queued
    repeat (3) tick();
    f0 = fall_cnt[1] + fall_cnt[2] + fall_cnt[3]; n1 = acc_q.size(); sw = '0;
    repeat (15) tick();
    chk("fall_pulses", 32'(fall_cnt[1] + fall_cnt[2] + fall_cnt[3] - f0), 3);
    chk("fall_no_event", 32'(acc_q.size() - n1), 0);
    // not ready: first grant held stable
    ready = 0; sw = 4'b1110;
    for (t = 0; t < 20 && !bus.event_valid; t++) tick();
    chk("hold_ch", 32'({bus.event_valid, bus.event_ch}), 32'({1'b1, 2'd1}));
    ok = 1;
    repeat (5) begin
      tick();
      if (!(bus.event_valid && bus.event_ch == 2'd1)) ok = 0;
    end
    chk("hold_stable", 32'(ok), 1);
    ready = 1; repeat (10) tick(); sw = '0; repeat (15) tick();
    // ch2 held 50 cycles
    n0 = acc_q.size(); rt = -1000; offs.delete(); sw[2] = 1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (k == 50) sw[2] = 0;
      if (bus.rise_pulse[2]) rt = k;
      if (bus.repeat_pulse[2]) offs.push_back(k - rt);
    end
    nrep = 0;
    for (int k = n0; k < acc_q.size(); k++) if (acc_q[k].rep && acc_q[k].ch == 2) nrep++;
`ifdef SWITCH_AUTOREPEAT_EN
    chk("rep_count", 32'(offs.size()), 4);
    if (offs.size() == 4) begin
      chk("rep_first", 32'(offs[0]), HM);
      chk("rep_second", 32'(offs[1]), HM + RM);
      chk("rep_fourth", 32'(offs[3]), HM + 3 * RM);
    end
    chk("rep_events", 32'(nrep), 4);
`else
    chk("rep_count", 32'(offs.size()), 0);
    chk("rep_events", 32'(nrep), 0);
`endif
    // reset mid-handshake
    ready = 0; sw[0] = 1;
    for (t = 0; t < 20 && !bus.event_valid; t++) tick();
    chk("rst_pre_valid", 32'(bus.event_valid), 1);
    rst = 1; tick();
    chk("rst_all_zero", all_outs(), 0);
    rst = 0; ok = 1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 7 && (bus.rise_pulse[0] || bus.level_out[0])) ok = 0;
    end
    chk("rst_no_early_rise", 32'(ok), 1);
    chk("rst_rise7", 32'(bus.rise_pulse[0]), 1);
    // random soak
    for (int i = 0; i < N; i++) dwell[i] = $urandom_range(1, 10);
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 599) == 0);
      ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        dwell[i]--;
        if (dwell[i] <= 0) begin
          sw[i] = ~sw[i];
          case ($urandom_range(0, 2))
            0: dwell[i] = $urandom_range(1, 6);
            1: dwell[i] = $urandom_range(5, 14);
            default: dwell[i] = $urandom_range(20, 60);
          endcase
        end
      end
    end
    rst = 0; tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
